// File: rtl/fetch_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_pkg
// Shared constants and types for the fetch PC generator: reset vector, AdEL
// exception code, 2-bit FSM state encoding, fetch stride and a misalignment
// helper.
// Build option: FETCH_DOUBLE_WORD_EN selects the 8-byte fetch stride.
// -----------------------------------------------------------------------------
package fetch_pc_gen_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [4:0]  EXC_ADEL     = 5'h04;

`ifdef FETCH_DOUBLE_WORD_EN
    localparam logic [31:0] FETCH_STRIDE = 32'd8;
`else
    localparam logic [31:0] FETCH_STRIDE = 32'd4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_STOP  = 2'd3
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_if
// Fetch request bus between the PC generator (master) and the instruction
// cache / MMU side (slave).
//   inst_req            master->slave  fetch request
//   inst_index_ok       slave->master  request accepted this cycle
//   PCR_VAddr_o         master->slave  request virtual address
//   FCT_hasException_o  master->slave  accepted request was misaligned
//   FCT_ExcCode_o       master->slave  AdEL when exception flagged, else 0
//   FCT_flush_o         master->slave  kill the in-flight accepted request
// -----------------------------------------------------------------------------
interface fetch_pc_gen_if;

    logic        inst_req;
    logic        inst_index_ok;
    logic [31:0] PCR_VAddr_o;
    logic        FCT_hasException_o;
    logic [4:0]  FCT_ExcCode_o;
    logic        FCT_flush_o;

    modport master (
        output inst_req,
        input  inst_index_ok,
        output PCR_VAddr_o,
        output FCT_hasException_o,
        output FCT_ExcCode_o,
        output FCT_flush_o
    );

    modport slave (
        input  inst_req,
        output inst_index_ok,
        input  PCR_VAddr_o,
        input  FCT_hasException_o,
        input  FCT_ExcCode_o,
        input  FCT_flush_o
    );

endinterface

// File: rtl/fetch_pc_gen_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC selection: CP0 redirect > branch redirect > sequential
// advance on acceptance > hold.
// Build option: FETCH_DOUBLE_WORD_EN rounds the sequential step to the next
// 8-byte fetch block instead of PC+4.
//   pc           current PC
//   cp0_flush    CP0 redirect request, cp0_target its target
//   br_redirect  branch redirect request, br_target its target
//   advance      request accepted this cycle
//   next_pc      PC for the next cycle
//   redirect     either redirect present
// -----------------------------------------------------------------------------
module fetch_next_pc
    import fetch_pc_gen_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        cp0_flush,
    input  logic [31:0] cp0_target,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        advance,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] seq_pc;

    always_comb begin
`ifdef FETCH_DOUBLE_WORD_EN
        seq_pc = {pc[31:3] + FETCH_STRIDE[31:3], 3'b000};
`else
        seq_pc = pc + FETCH_STRIDE;
`endif
        next_pc = pc;
        if (cp0_flush) begin
            next_pc = cp0_target;
        end else if (br_redirect) begin
            next_pc = br_target;
        end else if (advance) begin
            next_pc = seq_pc;
        end
    end

    assign redirect = cp0_flush | br_redirect;

endmodule

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Instruction fetch PC generator. Issues fetch requests, advances the PC on
// acceptance, applies CP0/branch redirects and flags misaligned fetches (AdEL).
// Build option: FETCH_DOUBLE_WORD_EN (8-byte sequential stride).
//   clk, rst                      clock, async active-low reset
//   CP0_flush_i / CP0_target_i    exception/ERET redirect and target
//   BR_redirect_i / BR_target_i   branch mispredict redirect and target
//   BE_stall_i                    backend full, hold further fetch
//   fch                           fetch request bus (master side)
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | after reset, no request, RUN next cycle
// ST_RUN   | requesting (gated off while BE_stall_i is high)
// ST_STALL | backend full, no request until BE_stall_i drops
// ST_STOP  | misaligned fetch accepted, waiting for a redirect
// -----------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CP0_flush_i,
    input  logic [31:0]           CP0_target_i,
    input  logic                  BR_redirect_i,
    input  logic [31:0]           BR_target_i,
    input  logic                  BE_stall_i,
    fetch_pc_gen_if.master        fch
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         exc_q;
    logic         flush_q;
    logic         req;
    logic         accept;
    logic         redirect;

    // Stall masks the request combinationally so nothing can be accepted
    // while the backend is full and the PC stays put.
    assign req    = (state_q == ST_RUN) && !BE_stall_i;
    assign accept = req && fch.inst_index_ok;

    fetch_next_pc u_next_pc (
        .pc          (pc_q),
        .cp0_flush   (CP0_flush_i),
        .cp0_target  (CP0_target_i),
        .br_redirect (BR_redirect_i),
        .br_target   (BR_target_i),
        .advance     (accept),
        .next_pc     (pc_d),
        .redirect    (redirect)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN: begin
                if (accept && is_misaligned(pc_q)) begin
                    state_d = ST_STOP;
                end else if (BE_stall_i) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: if (!BE_stall_i) state_d = ST_RUN;
            ST_STOP:  state_d = ST_STOP;
            default:  state_d = ST_IDLE;
        endcase
        if (redirect) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            exc_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            // A redirect on the accepting cycle kills the fetch, so its
            // misalignment is never reported.
            exc_q   <= accept && is_misaligned(pc_q) && !redirect;
            flush_q <= redirect;
        end
    end

    assign fch.inst_req           = req;
    assign fch.PCR_VAddr_o        = pc_q;
    assign fch.FCT_hasException_o = exc_q;
    assign fch.FCT_ExcCode_o      = exc_q ? EXC_ADEL : 5'h00;
    assign fch.FCT_flush_o        = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
// Self-checking bench for fetch_pc_gen: directed scenarios against constants
// plus a randomized run against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp0_flush;
    logic [31:0] cp0_target;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        be_stall;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_gen_if fch ();

    fetch_pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .CP0_flush_i   (cp0_flush),
        .CP0_target_i  (cp0_target),
        .BR_redirect_i (br_redirect),
        .BR_target_i   (br_target),
        .BE_stall_i    (be_stall),
        .fch           (fch)
    );

    always #5 clk = ~clk;

    // Behavioural model: fetch address, plus flags describing why fetch is
    // currently not allowed (just out of reset, halted on AdEL, backend stall).
    logic [31:0] m_pc;
    bit          m_boot, m_halted, m_in_stall, m_flush, m_exc;

    task automatic model_reset();
        m_pc = 32'hBFC00000;
        m_boot = 1; m_halted = 0; m_in_stall = 0; m_flush = 0; m_exc = 0;
    endtask

    function automatic logic [31:0] seq_addr(input logic [31:0] a);
`ifdef FETCH_DOUBLE_WORD_EN
        return (a & 32'hFFFFFFF8) + 32'd8;
`else
        return a + 32'd4;
`endif
    endfunction

    function automatic logic exp_req();
        return !m_boot && !m_halted && !m_in_stall && !be_stall;
    endfunction

    task automatic drive(input logic c, input logic [31:0] ct, input logic b,
                         input logic [31:0] bt, input logic s, input logic ok);
        cp0_flush = c; cp0_target = ct; br_redirect = b; br_target = bt;
        be_stall = s; fch.inst_index_ok = ok;
        #1;
    endtask

    task automatic tick();
        bit redir, acc, mis, halted_old, boot_old;
        redir = cp0_flush || br_redirect;
        acc = exp_req() && fch.inst_index_ok;
        mis = (m_pc % 4) != 0;
        halted_old = m_halted; boot_old = m_boot;
        if (cp0_flush) m_pc = cp0_target;
        else if (br_redirect) m_pc = br_target;
        else if (acc) m_pc = seq_addr(m_pc);
        m_flush = redir;
        m_exc = acc && mis && !redir;
        m_halted = !redir && (halted_old || (acc && mis));
        m_in_stall = !redir && !boot_old && !halted_old && be_stall;
        m_boot = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cp0_flush = 0; cp0_target = 0; br_redirect = 0; br_target = 0;
        be_stall = 0; fch.inst_index_ok = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (fch.inst_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", fch.inst_req); end
        n_checks++; if (fch.PCR_VAddr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL reset_pc: got %h want bfc00000", fch.PCR_VAddr_o); end
        n_checks++; if (fch.FCT_hasException_o !== 1'b0) begin n_errors++; $display("FAIL reset_exc: got %b want 0", fch.FCT_hasException_o); end
        n_checks++; if (fch.FCT_ExcCode_o !== 5'h00) begin n_errors++; $display("FAIL reset_code: got %h want 00", fch.FCT_ExcCode_o); end
        n_checks++; if (fch.FCT_flush_o !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %b want 0", fch.FCT_flush_o); end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        drive(0, 0, 0, 0, 0, 1);
        n_checks++; if (fch.inst_req !== 1'b0) begin n_errors++; $display("FAIL seq_idle_req: got %b want 0", fch.inst_req); end
        tick();
        want = 32'hBFC00000;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            n_checks++; if (fch.inst_req !== 1'b1 || fch.PCR_VAddr_o !== want) begin n_errors++; $display("FAIL seq_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, fch.inst_req, fch.PCR_VAddr_o, want); end
            tick();
            want = want + 32'd4;
        end
    endtask

    task automatic test_hold();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_checks++; if (fch.inst_req !== 1'b1 || fch.PCR_VAddr_o !== 32'hBFC00010) begin n_errors++; $display("FAIL hold_%0d: got req=%b addr=%h want req=1 addr=bfc00010", i, fch.inst_req, fch.PCR_VAddr_o); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.PCR_VAddr_o !== 32'hBFC00014) begin n_errors++; $display("FAIL hold_advance: got %h want bfc00014", fch.PCR_VAddr_o); end
        tick();
    endtask

    task automatic test_priority();
        drive(1, 32'hBFC00380, 1, 32'h80001000, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.PCR_VAddr_o !== 32'hBFC00380) begin n_errors++; $display("FAIL prio_target: got %h want bfc00380", fch.PCR_VAddr_o); end
        n_checks++; if (fch.FCT_flush_o !== 1'b1) begin n_errors++; $display("FAIL prio_flush: got %b want 1", fch.FCT_flush_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.FCT_flush_o !== 1'b0 || fch.PCR_VAddr_o !== 32'hBFC00380) begin n_errors++; $display("FAIL prio_after: got flush=%b addr=%h want flush=0 addr=bfc00380", fch.FCT_flush_o, fch.PCR_VAddr_o); end
        tick();
    endtask

    task automatic test_misaligned();
        drive(0, 0, 1, 32'h80000002, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++; if (fch.inst_req !== 1'b1 || fch.PCR_VAddr_o !== 32'h80000002) begin n_errors++; $display("FAIL mis_issue: got req=%b addr=%h want req=1 addr=80000002", fch.inst_req, fch.PCR_VAddr_o); end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++; if (fch.FCT_hasException_o !== 1'b1 || fch.FCT_ExcCode_o !== 5'h04) begin n_errors++; $display("FAIL mis_exc: got exc=%b code=%h want exc=1 code=04", fch.FCT_hasException_o, fch.FCT_ExcCode_o); end
        n_checks++; if (fch.inst_req !== 1'b0) begin n_errors++; $display("FAIL mis_stop_req: got %b want 0", fch.inst_req); end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++; if (fch.FCT_hasException_o !== 1'b0 || fch.FCT_ExcCode_o !== 5'h00 || fch.inst_req !== 1'b0) begin n_errors++; $display("FAIL mis_one_cycle: got exc=%b code=%h req=%b want 0/00/0", fch.FCT_hasException_o, fch.FCT_ExcCode_o, fch.inst_req); end
        tick();
        drive(1, 32'hBFC00380, 0, 0, 0, 1);
        n_checks++; if (fch.inst_req !== 1'b0) begin n_errors++; $display("FAIL mis_stop_hold: got %b want 0", fch.inst_req); end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++; if (fch.inst_req !== 1'b1 || fch.PCR_VAddr_o !== 32'hBFC00380 || fch.FCT_flush_o !== 1'b1) begin n_errors++; $display("FAIL mis_resume: got req=%b addr=%h flush=%b want 1/bfc00380/1", fch.inst_req, fch.PCR_VAddr_o, fch.FCT_flush_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.PCR_VAddr_o !== 32'hBFC00384) begin n_errors++; $display("FAIL mis_resume_adv: got %h want bfc00384", fch.PCR_VAddr_o); end
        tick();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 1);
            n_checks++; if (fch.inst_req !== 1'b0 || fch.PCR_VAddr_o !== 32'hBFC00384) begin n_errors++; $display("FAIL stall_%0d: got req=%b addr=%h want req=0 addr=bfc00384", i, fch.inst_req, fch.PCR_VAddr_o); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.inst_req !== 1'b0) begin n_errors++; $display("FAIL stall_exit: got req=%b want 0", fch.inst_req); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.inst_req !== 1'b1 || fch.PCR_VAddr_o !== 32'hBFC00384) begin n_errors++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=bfc00384", fch.inst_req, fch.PCR_VAddr_o); end
        tick();
    endtask

    task automatic test_redirect_accept();
        drive(0, 0, 1, 32'h80000100, 0, 1);
        n_checks++; if (fch.inst_req !== 1'b1 || fch.PCR_VAddr_o !== 32'hBFC00384) begin n_errors++; $display("FAIL racc_issue: got req=%b addr=%h want 1/bfc00384", fch.inst_req, fch.PCR_VAddr_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.PCR_VAddr_o !== 32'h80000100 || fch.FCT_flush_o !== 1'b1) begin n_errors++; $display("FAIL racc_target: got addr=%h flush=%b want 80000100/1", fch.PCR_VAddr_o, fch.FCT_flush_o); end
        tick();
        drive(0, 0, 1, 32'h80000201, 0, 0);
        tick();
        drive(1, 32'hBFC00380, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.FCT_hasException_o !== 1'b0 || fch.inst_req !== 1'b1 || fch.PCR_VAddr_o !== 32'hBFC00380) begin n_errors++; $display("FAIL racc_suppress: got exc=%b req=%b addr=%h want 0/1/bfc00380", fch.FCT_hasException_o, fch.inst_req, fch.PCR_VAddr_o); end
        tick();
    endtask

    task automatic test_wrap_stride();
        logic [31:0] want;
        drive(0, 0, 1, 32'hFFFFFFFC, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.PCR_VAddr_o !== 32'h00000000) begin n_errors++; $display("FAIL wrap: got %h want 00000000", fch.PCR_VAddr_o); end
        tick();
        drive(0, 0, 1, 32'h80000004, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++; if (fch.PCR_VAddr_o !== 32'h80000008) begin n_errors++; $display("FAIL stride_1: got %h want 80000008", fch.PCR_VAddr_o); end
        tick();
`ifdef FETCH_DOUBLE_WORD_EN
        want = 32'h80000010;
`else
        want = 32'h8000000C;
`endif
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (fch.PCR_VAddr_o !== want) begin n_errors++; $display("FAIL stride_2: got %h want %h", fch.PCR_VAddr_o, want); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1, 32'h80000040, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (fch.inst_req !== 1'b0 || fch.PCR_VAddr_o !== 32'hBFC00000) begin n_errors++; $display("FAIL rstmid_req: got req=%b addr=%h want 0/bfc00000", fch.inst_req, fch.PCR_VAddr_o); end
        n_checks++; if (fch.FCT_flush_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_flush: got %b want 0", fch.FCT_flush_o); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit          stall_r = 0;
        bit          c, b, ok;
        logic [31:0] ct, bt;
        for (int i = 0; i < 1500; i++) begin
            c = ($urandom_range(0, 39) == 0);
            b = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) stall_r = !stall_r;
            ok = $urandom_range(0, 1) == 1;
            ct = $urandom; bt = $urandom;
            if ($urandom_range(0, 5) != 0) begin ct = ct & 32'hFFFFFFFC; bt = bt & 32'hFFFFFFFC; end
            if ($urandom_range(0, 7) == 0) bt = 32'hFFFFFFF0 | (bt & 32'h0000000C);
            drive(c, ct, b, bt, stall_r, ok);
            n_checks++; if (fch.inst_req !== exp_req()) begin n_errors++; $display("FAIL rnd_req@%0d: got %b want %b", i, fch.inst_req, exp_req()); end
            n_checks++; if (fch.PCR_VAddr_o !== m_pc) begin n_errors++; $display("FAIL rnd_addr@%0d: got %h want %h", i, fch.PCR_VAddr_o, m_pc); end
            n_checks++; if (fch.FCT_hasException_o !== m_exc) begin n_errors++; $display("FAIL rnd_exc@%0d: got %b want %b", i, fch.FCT_hasException_o, m_exc); end
            n_checks++; if (fch.FCT_ExcCode_o !== (m_exc ? 5'h04 : 5'h00)) begin n_errors++; $display("FAIL rnd_code@%0d: got %h want %h", i, fch.FCT_ExcCode_o, (m_exc ? 5'h04 : 5'h00)); end
            n_checks++; if (fch.FCT_flush_o !== m_flush) begin n_errors++; $display("FAIL rnd_flush@%0d: got %b want %b", i, fch.FCT_flush_o, m_flush); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_priority();
        test_misaligned();
        test_stall();
        test_redirect_accept();
        test_wrap_stride();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
